// File: rtl/io_bank.sv
// Memory-mapped I/O bank: GPIO out/in, FIFO-buffered 8N1 UART transmitter and a
// 64-bit cycle counter whose upper half is snapshotted on each low-half read.
module io_bank #(
    parameter int unsigned GPIO_W         = 8,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned FIFO_DEPTH_LOG = 3,
    parameter int unsigned CLKS_PER_BIT   = 104
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [7:0]        io_addr,
    input  logic              io_en,
    input  logic              io_we,
    input  logic [31:0]       io_data_write,
    output logic [31:0]       io_data_read,
    output logic [GPIO_W-1:0] gpio_out,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic              uart_tx
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG:0] FullCnt = (FIFO_DEPTH_LOG + 1)'(FIFO_DEPTH);

    localparam logic [5:0] AddrGpioOut = 6'h00;
    localparam logic [5:0] AddrGpioIn  = 6'h01;
    localparam logic [5:0] AddrTxData  = 6'h02;
    localparam logic [5:0] AddrStatus  = 6'h03;
    localparam logic [5:0] AddrCycLo   = 6'h04;
    localparam logic [5:0] AddrCycHi   = 6'h05;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    logic [5:0] word;
    logic       wr_en, rd_en;
    logic       unused_bits;

    assign word        = io_addr[7:2];
    assign wr_en       = io_en & io_we;
    assign rd_en       = io_en & ~io_we;
    assign unused_bits = ^{io_addr[1:0], io_data_write};

    // GPIO
    logic [GPIO_W-1:0] gpio_out_q, gpio_meta_q, gpio_sync_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            gpio_out_q  <= '0;
            gpio_meta_q <= '0;
            gpio_sync_q <= '0;
        end else begin
            if (wr_en && word == AddrGpioOut) gpio_out_q <= io_data_write[GPIO_W-1:0];
            gpio_meta_q <= gpio_in;
            gpio_sync_q <= gpio_meta_q;
        end
    end

    assign gpio_out = gpio_out_q;

    // Cycle counter and high-half snapshot
    logic [63:0] cyc_q;
    logic [31:0] snap_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cyc_q  <= '0;
            snap_q <= '0;
        end else begin
            cyc_q <= cyc_q + 64'd1;
            if (rd_en && word == AddrCycLo) snap_q <= cyc_q[63:32];
        end
    end

    // TX FIFO
    logic [7:0]                fifo_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_DEPTH_LOG:0]   count_q, count_d;
    logic                      ovf_q, ovf_d;
    logic                      fifo_full, fifo_empty, push_req, push, pop, ovf_clr;
    tx_state_e                 state_q, state_d;

    assign fifo_full  = (count_q == FullCnt);
    assign fifo_empty = (count_q == '0);
    assign push_req   = wr_en && word == AddrTxData;
    // A full FIFO drops the byte even when a pop frees a slot this same cycle.
    assign push       = push_req && !fifo_full;
    assign pop        = (state_q == StIdle) && !fifo_empty;
    assign ovf_clr    = wr_en && word == AddrStatus && io_data_write[2];

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        ovf_d = (push_req && fifo_full) || (ovf_q && !ovf_clr);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= io_data_write[7:0];
    end

    // UART TX FSM
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             baud_last;

    assign baud_last = (baud_q == BaudLast);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    state_d = StStart;
                    shift_d = fifo_mem[rd_ptr_q];
                end
            end
            StStart: begin
                if (baud_last) begin
                    state_d   = StData;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) state_d = StStop;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_last) begin
                    state_d = StIdle;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Decoded from state so reset forces the line high without waiting for a clock
    always_comb begin
        uart_tx = 1'b1;
        unique case (state_q)
            StStart: uart_tx = 1'b0;
            StData:  uart_tx = shift_q[bit_idx_q];
            default: uart_tx = 1'b1;
        endcase
    end

    // Read mux
    always_comb begin
        io_data_read = '0;
        if (rd_en) begin
            case (word)
                AddrGpioOut: io_data_read[GPIO_W-1:0] = gpio_out_q;
                AddrGpioIn:  io_data_read[GPIO_W-1:0] = gpio_sync_q;
                AddrStatus: begin
                    io_data_read[0] = fifo_full;
                    io_data_read[1] = fifo_empty && (state_q == StIdle);
                    io_data_read[2] = ovf_q;
                    io_data_read[3 +: FIFO_DEPTH_LOG + 1] = count_q;
                end
                AddrCycLo: io_data_read = cyc_q[31:0];
                AddrCycHi: io_data_read = snap_q;
                default:   io_data_read = '0;
            endcase
        end
    end

endmodule
